// File: rtl/led_link_sequencer.sv
// led_link_sequencer
//   Port status LED sequencer: blink timebase, debounced aggregate link FSM
//   and merged TX/RX activity strobes feeding led_driver.
//   Optional build macro: LED_LAMP_TEST_EN (steady lamp test after reset).
module led_link_sequencer #(
    parameter int unsigned NUM_LANES        = 4,
    parameter int unsigned BLINK_DIV        = 15625000,
    parameter int unsigned LINK_DEBOUNCE    = 1048576,
    parameter int unsigned LAMP_TEST_CYCLES = 156250000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] lane_link,
    input  logic [NUM_LANES-1:0] lane_tx_frame,
    input  logic [NUM_LANES-1:0] lane_rx_frame,
    output logic                 has_link,
    output logic                 blink,
    output logic                 on_frame_sent,
    output logic                 on_frame_received,
    output logic [1:0]           link_state
);

    localparam logic [1:0] ST_DOWN  = 2'b00;
    localparam logic [1:0] ST_TRAIN = 2'b01;
    localparam logic [1:0] ST_UP    = 2'b10;
`ifdef LED_LAMP_TEST_EN
    localparam logic [1:0] ST_LAMP  = 2'b11;
    localparam logic [1:0] ST_RESET = ST_LAMP;
`else
    localparam logic [1:0] ST_RESET = ST_DOWN;
`endif

    localparam int unsigned DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SW = $clog2(LINK_DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(LINK_DEBOUNCE);

    // Zero-length periods make no sense for any of the timers.
    if (BLINK_DIV < 1 || LINK_DEBOUNCE < 1 || LAMP_TEST_CYCLES < 1) begin : g_param_check
        $error("led_link_sequencer: BLINK_DIV, LINK_DEBOUNCE and LAMP_TEST_CYCLES must be >= 1");
    end

    logic [NUM_LANES-1:0] link_q;
    logic [NUM_LANES-1:0] tx_q;
    logic [NUM_LANES-1:0] rx_q;
    logic                 all_up;
    logic                 any_up;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [DW-1:0]        div_cnt;
    logic                 div_wrap;
    logic                 blink_nxt;
    logic                 has_link_nxt;
    logic [SW-1:0]        stab_cnt;
    logic                 in_lamp;

    assign all_up     = &link_q;
    assign any_up     = |link_q;
    assign link_state = state;

`ifdef LED_LAMP_TEST_EN
    localparam int unsigned LW = (LAMP_TEST_CYCLES > 1) ? $clog2(LAMP_TEST_CYCLES) : 1;
    localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_TEST_CYCLES - 1);

    logic [LW-1:0] lamp_cnt;
    logic          lamp_done;

    assign in_lamp   = (state == ST_LAMP);
    assign lamp_done = (lamp_cnt == LAMP_LAST);

    // Lamp-test duration counter; parks at its last value once the test ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lamp_cnt <= '0;
        else if (in_lamp && !lamp_done)
            lamp_cnt <= lamp_cnt + 1'b1;
    end
`else
    assign in_lamp = 1'b0;
`endif

    // Input stage: one register on every lane input, all decisions use these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            link_q <= lane_link;
            tx_q   <= lane_tx_frame;
            rx_q   <= lane_rx_frame;
        end
    end

    // Next blink level: toggle at prescaler wrap, forced low during lamp test.
    always_comb begin
        div_wrap  = (div_cnt == DIV_LAST);
        blink_nxt = blink;
        if (in_lamp)
            blink_nxt = 1'b0;
        else if (div_wrap)
            blink_nxt = ~blink;
    end

    // Blink prescaler: div_cnt runs 0..BLINK_DIV-1, held at 0 during lamp test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            blink   <= 1'b0;
        end else begin
            blink <= blink_nxt;
            if (in_lamp || div_wrap)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    // Debounce: count consecutive all-lanes-up cycles, saturating at LINK_DEBOUNCE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stab_cnt <= '0;
        else if (in_lamp || !all_up)
            stab_cnt <= '0;
        else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 1'b1;
    end

    // Link FSM next state; all_up is rechecked in TRAIN so a drop on the
    // saturation cycle cannot promote to UP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DOWN: begin
                if (any_up)
                    state_nxt = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (!any_up)
                    state_nxt = ST_DOWN;
                else if (all_up && (stab_cnt == STAB_MAX))
                    state_nxt = ST_UP;
            end
            ST_UP: begin
                if (!any_up)
                    state_nxt = ST_DOWN;
                else if (!all_up)
                    state_nxt = ST_TRAIN;
            end
`ifdef LED_LAMP_TEST_EN
            ST_LAMP: begin
                if (lamp_done)
                    state_nxt = ST_DOWN;
            end
`endif
            default: state_nxt = ST_DOWN;
        endcase
    end

    // has_link derived from the next state so it lines up with link_state.
    always_comb begin
        has_link_nxt = 1'b0;
        case (state_nxt)
            ST_TRAIN: has_link_nxt = blink_nxt;
            ST_UP:    has_link_nxt = 1'b1;
`ifdef LED_LAMP_TEST_EN
            ST_LAMP:  has_link_nxt = 1'b1;
`endif
            default:  has_link_nxt = 1'b0;
        endcase
    end

    // State and has_link registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            has_link <= 1'b0;
        end else begin
            state    <= state_nxt;
            has_link <= has_link_nxt;
        end
    end

    // Activity strobes: lanes merged, gated by the current state so a frame
    // seen in the same cycle as a link drop still produces its strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_frame_sent     <= 1'b0;
            on_frame_received <= 1'b0;
        end else begin
            on_frame_sent     <= (state == ST_UP) && (|tx_q);
            on_frame_received <= (state == ST_UP) && (|rx_q);
        end
    end

endmodule
